// File: rtl/csa_pipe_adder.sv
// Two-stage pipelined carry-select adder/subtractor with valid/ready
// handshakes on both sides. Stage 1 forms a conditional sum/carry pair per
// select block; stage 2 resolves the select chain and registers the result.
module csa_pipe_adder #(
  parameter int WIDTH   = 16,
  parameter int BLOCK_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_add_term1,
  input  logic [WIDTH-1:0] i_add_term2,
  input  logic             i_cin,
  input  logic             i_sub,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf,
  output logic             o_valid,
  input  logic             i_ready
);

  localparam int NB = (WIDTH + BLOCK_W - 1) / BLOCK_W;

  // Operand conditioning: subtraction is A + ~B + 1, carry-in ignored.
  logic [WIDTH-1:0] b_mod;
  logic             c0;
  assign b_mod = i_sub ? ~i_add_term2 : i_add_term2;
  assign c0    = i_sub | i_cin;

  // Per-block candidate results. Block 0 sees the real carry-in in both
  // candidates, so whichever one the select chain picks is the true sum.
  logic [WIDTH-1:0] sum0_d, sum1_d;
  logic [NB-1:0]    carry0_d, carry1_d;

  for (genvar k = 0; k < NB; k++) begin : g_blk
    localparam int LO = k * BLOCK_W;
    localparam int BW = ((WIDTH - LO) < BLOCK_W) ? (WIDTH - LO) : BLOCK_W;
    logic          cin0, cin1;
    logic [BW:0]   r0, r1;
    assign cin0 = (k == 0) ? c0 : 1'b0;
    assign cin1 = (k == 0) ? c0 : 1'b1;
    assign r0 = {1'b0, i_add_term1[LO +: BW]} + {1'b0, b_mod[LO +: BW]} + {{BW{1'b0}}, cin0};
    assign r1 = {1'b0, i_add_term1[LO +: BW]} + {1'b0, b_mod[LO +: BW]} + {{BW{1'b0}}, cin1};
    assign sum0_d[LO +: BW] = r0[BW-1:0];
    assign sum1_d[LO +: BW] = r1[BW-1:0];
    assign carry0_d[k]      = r0[BW];
    assign carry1_d[k]      = r1[BW];
  end

  // Stage-1 state
  logic             s1_valid;
  logic [WIDTH-1:0] s1_sum0, s1_sum1;
  logic [NB-1:0]    s1_carry0, s1_carry1;
  logic             s1_a_msb, s1_b_msb;
  logic             rst_done;

  // Flow control: each stage advances when it is empty or its consumer moves.
  logic s2_adv, s1_adv, in_fire;
  assign s2_adv  = !o_valid || i_ready;
  assign s1_adv  = !s1_valid || s2_adv;
  assign o_ready = rst_done && s1_adv;
  assign in_fire = i_valid && o_ready;

  // Stage-2 select chain over the registered candidates.
  logic [NB-1:0]    blk_cin;
  logic             chain;
  logic [WIDTH-1:0] res;
  logic             res_ovf;

  // Resolve the carry-select chain and pick each block's sum.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through it leaves a variable unassigned and no latch is inferred.
    blk_cin = '0;
    chain   = 1'b0;
    res     = '0;
    for (int k = 0; k < NB; k++) begin
      blk_cin[k] = chain;
      chain      = chain ? s1_carry1[k] : s1_carry0[k];
    end
    for (int i = 0; i < WIDTH; i++) begin
      res[i] = blk_cin[i / BLOCK_W] ? s1_sum1[i] : s1_sum0[i];
    end
    res_ovf = (s1_a_msb == s1_b_msb) && (res[WIDTH-1] != s1_a_msb);
  end

  // Stage 1: capture candidate sums on an input transfer.
  always_ff @(posedge i_clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!i_rst_n) begin
      // NOTE: data registers are cleared too, so a reset leaves no stale
      // operand that could later leak out of the pipeline.
      rst_done  <= 1'b0;
      s1_valid  <= 1'b0;
      s1_sum0   <= '0;
      s1_sum1   <= '0;
      s1_carry0 <= '0;
      s1_carry1 <= '0;
      s1_a_msb  <= 1'b0;
      s1_b_msb  <= 1'b0;
    end else begin
      rst_done <= 1'b1;
      if (s1_adv) begin
        s1_valid <= in_fire;
        if (in_fire) begin
          s1_sum0   <= sum0_d;
          s1_sum1   <= sum1_d;
          s1_carry0 <= carry0_d;
          s1_carry1 <= carry1_d;
          s1_a_msb  <= i_add_term1[WIDTH-1];
          s1_b_msb  <= b_mod[WIDTH-1];
        end
      end
    end
  end

  // Stage 2: register the resolved result; hold it while downstream stalls.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_sum   <= '0;
      o_cout  <= 1'b0;
      o_ovf   <= 1'b0;
    end else if (s2_adv) begin
      o_valid <= s1_valid;
      if (s1_valid) begin
        o_sum  <= res;
        o_cout <= chain;
        o_ovf  <= res_ovf;
      end
    end
  end

endmodule

// File: tb/tb_csa_pipe_adder.sv
// Self-checking bench for csa_pipe_adder: a 16/4 instance for the directed
// table, backpressure and reset sequences, and a 7/3 instance for uneven
// blocks plus a short streaming run against a behavioural model.
module tb_csa_pipe_adder;

  logic i_clk;
  logic i_rst_n;

  // 16-bit, 4-bit block instance
  logic [15:0] a16, b16, o_sum16;
  logic        cin16, sub16, v16, r16, o_ready16, o_cout16, o_ovf16, o_valid16;

  // 7-bit, 3-bit block instance
  logic [6:0]  a7, b7, o_sum7;
  logic        cin7, sub7, v7, r7, o_ready7, o_cout7, o_ovf7, o_valid7;

  csa_pipe_adder #(.WIDTH(16), .BLOCK_W(4)) u_dut16 (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_add_term1(a16), .i_add_term2(b16), .i_cin(cin16), .i_sub(sub16),
    .i_valid(v16), .o_ready(o_ready16),
    .o_sum(o_sum16), .o_cout(o_cout16), .o_ovf(o_ovf16),
    .o_valid(o_valid16), .i_ready(r16)
  );

  csa_pipe_adder #(.WIDTH(7), .BLOCK_W(3)) u_dut7 (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_add_term1(a7), .i_add_term2(b7), .i_cin(cin7), .i_sub(sub7),
    .i_valid(v7), .o_ready(o_ready7),
    .o_sum(o_sum7), .o_cout(o_cout7), .o_ovf(o_ovf7),
    .o_valid(o_valid7), .i_ready(r7)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [8:0] model7(input logic [6:0] a, input logic [6:0] b,
                                        input logic cin, input logic sub);
    logic [6:0] bm;
    logic [7:0] t;
    bm = sub ? ~b : b;
    t  = {1'b0, a} + {1'b0, bm} + {7'b0, (sub | cin)};
    return {(a[6] == bm[6]) && (t[6] != a[6]), t[7], t[6:0]};
  endfunction

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t       vecs[12];
  logic [8:0] q7[$];
  logic [8:0] snap, expv;
  logic       fin, fout;

  initial begin
    vecs[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[2]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[3]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4]  = '{16'h7FFF, 16'h0001, 1'b1, 1'b0, 16'h8001, 1'b0, 1'b1};
    vecs[5]  = '{16'h0010, 16'h0010, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[6]  = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[7]  = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[8]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[9]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[10] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[11] = '{16'h00F0, 16'h0010, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};

    a16 = '0; b16 = '0; cin16 = 0; sub16 = 0; v16 = 0; r16 = 1;
    a7  = '0; b7  = '0; cin7  = 0; sub7  = 0; v7  = 0; r7  = 1;

    // Reset state
    i_rst_n = 1'b0;
    tick();
    tick();
    check("rst_o_valid", o_valid16, 0);
    check("rst_o_sum",   o_sum16,   0);
    check("rst_o_cout",  o_cout16,  0);
    check("rst_o_ovf",   o_ovf16,   0);
    check("rst_o_ready", o_ready16, 0);
    i_rst_n = 1'b1;
    #1;
    check("rst_release_ready_low", o_ready16, 0);
    tick();
    check("rst_release_ready_high", o_ready16, 1);

    // Directed table, one beat at a time with downstream always ready
    for (int i = 0; i < 12; i++) begin
      a16 = vecs[i].a; b16 = vecs[i].b; cin16 = vecs[i].cin; sub16 = vecs[i].sub;
      v16 = 1'b1;
      tick();
      v16 = 1'b0;
      check($sformatf("v%0d_valid_lat1", i), o_valid16, 0);
      tick();
      check($sformatf("v%0d_valid", i), o_valid16, 1);
      check($sformatf("v%0d_sum", i),   o_sum16,   vecs[i].sum);
      check($sformatf("v%0d_cout", i),  o_cout16,  vecs[i].cout);
      check($sformatf("v%0d_ovf", i),   o_ovf16,   vecs[i].ovf);
    end
    tick();
    check("idle_valid", o_valid16, 0);

    // Backpressure: 1+1..4+4 with downstream stalled for a few cycles
    cin16 = 0; sub16 = 0; r16 = 0;
    a16 = 16'd1; b16 = 16'd1; v16 = 1;
    #1;
    check("bp_ready_empty", o_ready16, 1);
    tick();
    check("bp_ready_s1_full", o_ready16, 1);
    a16 = 16'd2; b16 = 16'd2;
    tick();
    a16 = 16'd3; b16 = 16'd3;
    check("bp_first_valid", o_valid16, 1);
    check("bp_first_sum",   o_sum16,   16'd2);
    check("bp_ready_full",  o_ready16, 0);
    for (int c = 0; c < 2; c++) begin
      tick();
      check($sformatf("bp_hold%0d_sum", c),   o_sum16,   16'd2);
      check($sformatf("bp_hold%0d_valid", c), o_valid16, 1);
      check($sformatf("bp_hold%0d_ready", c), o_ready16, 0);
    end
    r16 = 1;
    #1;
    check("bp_ready_release", o_ready16, 1);
    tick();
    check("bp_out2_sum", o_sum16, 16'd4);
    check("bp_out2_valid", o_valid16, 1);
    a16 = 16'd4; b16 = 16'd4;
    tick();
    v16 = 0;
    check("bp_out3_sum", o_sum16, 16'd6);
    tick();
    check("bp_out4_sum", o_sum16, 16'd8);
    check("bp_out4_valid", o_valid16, 1);
    tick();
    check("bp_drained", o_valid16, 0);

    // Reset with two beats in flight
    a16 = 16'd5; b16 = 16'd5; v16 = 1;
    tick();
    a16 = 16'd6; b16 = 16'd6;
    tick();
    v16 = 0;
    check("mr_pre_valid", o_valid16, 1);
    check("mr_pre_sum",   o_sum16,   16'd10);
    i_rst_n = 0;
    tick();
    i_rst_n = 1;
    check("mr_valid", o_valid16, 0);
    check("mr_sum",   o_sum16,   0);
    check("mr_ready", o_ready16, 0);
    tick();
    check("mr_ready_after", o_ready16, 1);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("mr_no_stale%0d", c), o_valid16, 0);
      tick();
    end

    // Uneven blocks, directed
    a7 = 7'h7F; b7 = 7'h01; cin7 = 0; sub7 = 0; v7 = 1;
    tick();
    v7 = 0;
    tick();
    check("u7_a_valid", o_valid7, 1);
    check("u7_a_sum",   o_sum7,   7'h00);
    check("u7_a_cout",  o_cout7,  1);
    check("u7_a_ovf",   o_ovf7,   0);
    a7 = 7'h2A; b7 = 7'h15; v7 = 1;
    tick();
    v7 = 0;
    tick();
    check("u7_b_sum",  o_sum7,  7'h3F);
    check("u7_b_cout", o_cout7, 0);
    check("u7_b_ovf",  o_ovf7,  0);
    tick();

    // Uneven blocks, streaming with random valid/ready against the model
    for (int n = 0; n < 308; n++) begin
      if (n < 300) begin
        a7 = 7'($urandom); b7 = 7'($urandom);
        cin7 = 1'($urandom); sub7 = 1'($urandom);
        v7 = ($urandom_range(0, 3) != 0);
        r7 = ($urandom_range(0, 3) != 0);
      end else begin
        v7 = 0;
        r7 = 1;
      end
      #2;
      fin  = v7 && o_ready7;
      fout = o_valid7 && r7;
      snap = {o_ovf7, o_cout7, o_sum7};
      expv = model7(a7, b7, cin7, sub7);
      tick();
      if (fout) begin
        if (q7.size() == 0) begin
          check("s7_extra_beat", 1, 0);
        end else begin
          check($sformatf("s7_beat%0d", n), snap, q7.pop_front());
        end
      end
      if (fin) q7.push_back(expv);
    end
    check("s7_all_delivered", q7.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
